de0_lt24_irq_ctrl: RTL and testbench

Avalon-MM interrupt controller sitting directly downstream of the SOPC interval timer and the other peripheral IRQ lines. It latches up to 16 interrupt sources as edge- or level-sensitive, applies a mask, and presents a single combined `irq` to the CPU. It also presents a priority-encoded vector so the handler can identify the winning source with one read. The register file is 16-bit with 1-cycle registered read latency, matching the timer's bus behaviour.

---
 rtl/de0_lt24_irq_pkg.sv | 14 +
 rtl/de0_lt24_irq_ctrl_if.sv | 12 +
 rtl/de0_lt24_irq_prio_enc.sv | 12 +
 rtl/de0_lt24_irq_ctrl.sv | 52 +++++
 tb/tb_de0_lt24_irq_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/de0_lt24_irq_pkg.sv
// de0_lt24_irq_pkg: register map and shared constants for the interrupt controller
package de0_lt24_irq_pkg;
  localparam int IRQ_MAX_SRC = 16;
  localparam int IRQ_VEC_VALID_BIT = 15;
  localparam logic [2:0] IRQ_ADDR_PENDING = 3'd0;
  localparam logic [2:0] IRQ_ADDR_MASK = 3'd1;
  localparam logic [2:0] IRQ_ADDR_EDGE = 3'd2;
  localparam logic [2:0] IRQ_ADDR_ACTIVE = 3'd3;
  localparam logic [2:0] IRQ_ADDR_VECTOR = 3'd4;
  localparam logic [2:0] IRQ_ADDR_SWSET = 3'd5;
  function automatic logic [15:0] src_mask(int n);
    return 16'((32'd1 << n) - 32'd1);
  endfunction
endpackage

// File: rtl/de0_lt24_irq_ctrl_if.sv
// de0_lt24_irq_ctrl_if: Avalon-MM slave bus plus interrupt lines of the controller
interface de0_lt24_irq_ctrl_if #(parameter int NUM_SRC = 8);
  logic [2:0] address;
  logic chipselect;
  logic write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [NUM_SRC-1:0] irq_in;
  logic irq;
  modport master(output address, chipselect, write_n, writedata, irq_in, input readdata, irq);
  modport slave(input address, chipselect, write_n, writedata, irq_in, output readdata, irq);
endinterface

// File: rtl/de0_lt24_irq_prio_enc.sv
// de0_lt24_irq_prio_enc: lowest-index-first priority encoder over 16 lines
module de0_lt24_irq_prio_enc (
  input  logic [15:0] i_vec,
  output logic        o_valid,
  output logic [3:0]  o_id
);
  always_comb begin
    o_id = '0;
    for (int k = 15; k >= 0; k--) if (i_vec[k]) o_id = 4'(k);
  end
  assign o_valid = |i_vec;
endmodule

// File: rtl/de0_lt24_irq_ctrl.sv
// de0_lt24_irq_ctrl: edge/level interrupt latch, mask and vector with registered 16-bit reads
module de0_lt24_irq_ctrl
  import de0_lt24_irq_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input logic clk,
  input logic reset,
  de0_lt24_irq_ctrl_if.slave bus
);
  localparam logic [15:0] SRC_MASK = src_mask(NUM_SRC);
  logic [15:0] r_pend, r_mask, r_edge, r_prev, r_rdata;
  logic [15:0] w_in, w_wdata, w_w1c, w_sw, w_active, w_vector, w_pend_nxt, w_rd;
  logic w_wr, w_valid;
  logic [3:0] w_id;
  assign w_in = 16'(bus.irq_in) & SRC_MASK;
  assign w_wr = bus.chipselect && !bus.write_n;
  assign w_wdata = bus.writedata & SRC_MASK;
  assign w_w1c = (w_wr && bus.address == IRQ_ADDR_PENDING) ? w_wdata : '0;
  assign w_sw = (w_wr && bus.address == IRQ_ADDR_SWSET) ? w_wdata : '0;
  // edge bits: set terms OR'd after the clear so a coincident event survives a W1C
  assign w_pend_nxt = (r_edge & ((r_pend & ~w_w1c) | (w_in & ~r_prev) | w_sw)) | (~r_edge & w_in);
  assign w_active = r_pend & r_mask;
  de0_lt24_irq_prio_enc u_prio (
    .i_vec  (w_active),
    .o_valid(w_valid),
    .o_id   (w_id)
  );
  assign w_vector = (16'(w_valid) << IRQ_VEC_VALID_BIT) | 16'(w_id);
  assign w_rd = (bus.address == IRQ_ADDR_PENDING) ? r_pend :
                (bus.address == IRQ_ADDR_MASK)    ? r_mask :
                (bus.address == IRQ_ADDR_EDGE)    ? r_edge :
                (bus.address == IRQ_ADDR_ACTIVE)  ? w_active :
                (bus.address == IRQ_ADDR_VECTOR)  ? w_vector : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
      r_mask <= '0;
      r_edge <= '0;
      r_prev <= '0;
      r_rdata <= '0;
    end else begin
      r_prev <= w_in;
      r_pend <= w_pend_nxt;
      if (w_wr && bus.address == IRQ_ADDR_MASK) r_mask <= w_wdata;
      if (w_wr && bus.address == IRQ_ADDR_EDGE) r_edge <= w_wdata;
      r_rdata <= w_rd;
    end
  end
  assign bus.readdata = r_rdata;
  assign bus.irq = |w_active;
endmodule

// File: tb/tb_de0_lt24_irq_ctrl.sv
// tb_de0_lt24_irq_ctrl: directed tests of the interrupt controller register file and irq
module tb_de0_lt24_irq_ctrl;
  import de0_lt24_irq_pkg::*;
  logic clk = 0;
  logic reset = 1;
  int checks = 0;
  int errors = 0;
  de0_lt24_irq_ctrl_if #(.NUM_SRC(8)) bus ();
  de0_lt24_irq_ctrl #(.NUM_SRC(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1; bus.write_n = 0; bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 0; bus.write_n = 1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1;
    @(negedge clk);
    d = bus.readdata; bus.chipselect = 0;
  endtask

  task automatic test_reset;
    logic [15:0] d;
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      checks++;
      if (d !== 16'h0000) begin errors++; $display("FAIL reset_read addr %0d got %h want 0000", a, d); end
    end
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", bus.irq); end
  endtask

  task automatic test_edge;
    logic [15:0] d;
    wr(IRQ_ADDR_EDGE, 16'h0001);
    wr(IRQ_ADDR_MASK, 16'h0001);
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL edge_idle got %b want 0", bus.irq); end
    @(negedge clk); bus.irq_in = 8'h01;
    @(negedge clk); bus.irq_in = 8'h00;
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL edge_rise got %b want 1", bus.irq); end
    @(negedge clk);
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL edge_hold got %b want 1", bus.irq); end
    rd(IRQ_ADDR_PENDING, d);
    checks++;
    if (d !== 16'h0001) begin errors++; $display("FAIL edge_pend got %h want 0001", d); end
    wr(IRQ_ADDR_PENDING, 16'h0001);
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL edge_w1c got %b want 0", bus.irq); end
  endtask

  task automatic test_level;
    wr(IRQ_ADDR_EDGE, 16'h0000);
    wr(IRQ_ADDR_MASK, 16'h0008);
    @(negedge clk); bus.irq_in = 8'h08; bus.address = IRQ_ADDR_PENDING;
    @(negedge clk);
    checks++;
    if (bus.readdata !== 16'h0000) begin errors++; $display("FAIL lvl_lag got %h want 0000", bus.readdata); end
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL lvl_irq got %b want 1", bus.irq); end
    @(negedge clk);
    checks++;
    if (bus.readdata !== 16'h0008) begin errors++; $display("FAIL lvl_pend got %h want 0008", bus.readdata); end
    bus.chipselect = 1; bus.write_n = 0; bus.writedata = 16'h0008;
    @(negedge clk);
    bus.chipselect = 0; bus.write_n = 1;
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL lvl_w1c_irq got %b want 1", bus.irq); end
    @(negedge clk);
    checks++;
    if (bus.readdata !== 16'h0008) begin errors++; $display("FAIL lvl_w1c_pend got %h want 0008", bus.readdata); end
    @(negedge clk);
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL lvl_last got %b want 1", bus.irq); end
    bus.irq_in = 8'h00;
    @(negedge clk);
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL lvl_fall got %b want 0", bus.irq); end
  endtask

  task automatic test_vector;
    logic [15:0] d;
    wr(IRQ_ADDR_EDGE, 16'h0024);
    wr(IRQ_ADDR_MASK, 16'h0000);
    @(negedge clk); bus.irq_in = 8'h24;
    @(negedge clk); bus.irq_in = 8'h00;
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL vec_masked got %b want 0", bus.irq); end
    wr(IRQ_ADDR_MASK, 16'h0024);
    rd(IRQ_ADDR_VECTOR, d);
    checks++;
    if (d !== 16'h8002) begin errors++; $display("FAIL vec_two got %h want 8002", d); end
    rd(IRQ_ADDR_ACTIVE, d);
    checks++;
    if (d !== 16'h0024) begin errors++; $display("FAIL vec_active got %h want 0024", d); end
    wr(IRQ_ADDR_PENDING, 16'h0004);
    rd(IRQ_ADDR_VECTOR, d);
    checks++;
    if (d !== 16'h8005) begin errors++; $display("FAIL vec_five got %h want 8005", d); end
    wr(IRQ_ADDR_PENDING, 16'h0004);
    wr(IRQ_ADDR_MASK, 16'h0000);
    rd(IRQ_ADDR_VECTOR, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL vec_none got %h want 0000", d); end
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL vec_irq got %b want 0", bus.irq); end
    rd(IRQ_ADDR_PENDING, d);
    checks++;
    if (d !== 16'h0020) begin errors++; $display("FAIL vec_pend got %h want 0020", d); end
  endtask

  task automatic test_set_wins;
    logic [15:0] d;
    wr(IRQ_ADDR_PENDING, 16'hFFFF);
    wr(IRQ_ADDR_EDGE, 16'h0002);
    wr(IRQ_ADDR_MASK, 16'h0002);
    @(negedge clk);
    bus.irq_in = 8'h02; bus.address = IRQ_ADDR_PENDING;
    bus.chipselect = 1; bus.write_n = 0; bus.writedata = 16'h0002;
    @(negedge clk);
    bus.chipselect = 0; bus.write_n = 1; bus.irq_in = 8'h00;
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL setwin_irq got %b want 1", bus.irq); end
    rd(IRQ_ADDR_PENDING, d);
    checks++;
    if (d !== 16'h0002) begin errors++; $display("FAIL setwin_pend got %h want 0002", d); end
  endtask

  task automatic test_swset;
    logic [15:0] d;
    wr(IRQ_ADDR_PENDING, 16'hFFFF);
    wr(IRQ_ADDR_EDGE, 16'h0080);
    wr(IRQ_ADDR_MASK, 16'h0080);
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL sw_idle got %b want 0", bus.irq); end
    wr(IRQ_ADDR_SWSET, 16'h0080);
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL sw_irq got %b want 1", bus.irq); end
    rd(IRQ_ADDR_SWSET, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL sw_read got %h want 0000", d); end
    wr(IRQ_ADDR_PENDING, 16'h0080);
    wr(IRQ_ADDR_EDGE, 16'h0000);
    wr(IRQ_ADDR_SWSET, 16'h0080);
    rd(IRQ_ADDR_PENDING, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL sw_level got %h want 0000", d); end
    wr(IRQ_ADDR_MASK, 16'hFFFF);
    rd(IRQ_ADDR_MASK, d);
    checks++;
    if (d !== 16'h00FF) begin errors++; $display("FAIL mask_width got %h want 00ff", d); end
    wr(3'd6, 16'hFFFF);
    rd(3'd6, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL addr6 got %h want 0000", d); end
  endtask

  task automatic test_mid_reset;
    logic [15:0] d;
    @(negedge clk); bus.irq_in = 8'h01;
    @(negedge clk);
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL rst_pre got %b want 1", bus.irq); end
    reset = 1;
    @(negedge clk);
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b want 0", bus.irq); end
    reset = 0; bus.irq_in = 8'h00;
    rd(IRQ_ADDR_MASK, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL rst_mask got %h want 0000", d); end
  endtask

  initial begin
    bus.address = '0; bus.chipselect = 0; bus.write_n = 1; bus.writedata = '0; bus.irq_in = '0;
    test_reset;
    test_edge;
    test_level;
    test_vector;
    test_set_wins;
    test_swset;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
